// File: rtl/stack_calculator.sv
// RPN stack calculator feeding picture_generator: one command per handshake,
// three-state IDLE/EXEC/COMMIT sequence, registered numbers/depth/err outputs.
module stack_calculator #(
  parameter int DEPTH = 15,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd,
  input  logic [WIDTH-1:0]       operand,
  output logic                   busy,
  output logic [DEPTH*WIDTH-1:0] numbers,
  output logic [3:0]             depth,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_MUL, OP_SWAP, OP_CLEAR
  } opcode_e;

  localparam logic [3:0] FULL = 4'(DEPTH);

  state_e           state_q, state_d;
  opcode_e          cmd_q, cmd_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] sec_q, sec_d;
  logic [3:0]       lat_depth_q, lat_depth_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] slots_q [DEPTH];
  logic [WIDTH-1:0] slots_d [DEPTH];
  logic [3:0]       depth_q, depth_d;
  logic             err_q, err_d;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    cmd_d       = cmd_q;
    operand_d   = operand_q;
    top_d       = top_q;
    sec_d       = sec_q;
    lat_depth_d = lat_depth_q;
    result_d    = result_q;
    fault_d     = fault_q;
    slots_d     = slots_q;
    depth_d     = depth_q;
    err_d       = err_q;
    product     = sec_q * top_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = EXEC;
          cmd_d       = opcode_e'(cmd);
          operand_d   = operand;
          lat_depth_d = depth_q;
          top_d       = (depth_q >= 4'd1) ? slots_q[depth_q - 4'd1] : '0;
          sec_d       = (depth_q >= 4'd2) ? slots_q[depth_q - 4'd2] : '0;
        end
      end

      EXEC: begin
        state_d  = COMMIT;
        result_d = '0;
        fault_d  = 1'b0;
        unique case (cmd_q)
          OP_PUSH: fault_d = (lat_depth_q == FULL);
          OP_POP:  fault_d = (lat_depth_q == 4'd0);
          OP_ADD:  begin fault_d = (lat_depth_q < 4'd2); result_d = sec_q + top_q; end
          OP_SUB:  begin fault_d = (lat_depth_q < 4'd2); result_d = sec_q - top_q; end
          OP_MUL:  begin fault_d = (lat_depth_q < 4'd2); result_d = product[WIDTH-1:0]; end
          OP_SWAP: fault_d = (lat_depth_q < 4'd2);
          default: ;
        endcase
      end

      COMMIT: begin
        state_d = IDLE;
        err_d   = fault_q;
        // A fault leaves the stack untouched; only err records it.
        if (!fault_q) begin
          unique case (cmd_q)
            OP_PUSH: begin
              slots_d[lat_depth_q] = operand_q;
              depth_d              = lat_depth_q + 4'd1;
            end
            OP_POP: begin
              slots_d[lat_depth_q - 4'd1] = '0;
              depth_d                     = lat_depth_q - 4'd1;
            end
            OP_ADD, OP_SUB, OP_MUL: begin
              slots_d[lat_depth_q - 4'd2] = result_q;
              slots_d[lat_depth_q - 4'd1] = '0;
              depth_d                     = lat_depth_q - 4'd1;
            end
            OP_SWAP: begin
              slots_d[lat_depth_q - 4'd2] = top_q;
              slots_d[lat_depth_q - 4'd1] = sec_q;
            end
            OP_CLEAR: begin
              for (int i = 0; i < DEPTH; i++) slots_d[i] = '0;
              depth_d = 4'd0;
            end
            default: ;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_q       <= OP_NOP;
      operand_q   <= '0;
      top_q       <= '0;
      sec_q       <= '0;
      lat_depth_q <= '0;
      result_q    <= '0;
      fault_q     <= 1'b0;
      // NOTE: the slot array is reset, not left undefined, because it drives the display directly.
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      operand_q   <= operand_d;
      top_q       <= top_d;
      sec_q       <= sec_d;
      lat_depth_q <= lat_depth_d;
      result_q    <= result_d;
      fault_q     <= fault_d;
      slots_q     <= slots_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign depth = depth_q;
  assign err   = err_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign numbers[WIDTH*g +: WIDTH] = slots_q[g];
  end

endmodule
